i2c_slave_responder: RTL

I2C target (slave) that answers the byte-write and register-read transactions issued by the team's I2C configuration masters. Used in loop-back benches and on-board bridges so that an FPGA can present a configurable register space to a master.
It decodes START, STOP and repeated START, matches a 7-bit device address, and keeps an auto-incrementing 8-bit register pointer. Data moves through a simple register-bus handshake toward the register file owned by the parent. It drives SDA only, using the team's open-drain pad convention, and never stretches SCL.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_cond.sv | 50 +++++
 rtl/i2c_slave_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_pkg : shared states and bus constants for the I2C target      |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEV_ADDR = 3'd1,
    ST_REG_ADDR = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_RD_ACK   = 3'd5,
    ST_ACK      = 3'd6
  } state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_line_cond.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_line_cond : SCL/SDA synchronizers, edge and START/STOP detect |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;

  // Idle bus is high; resetting to 1 avoids a phantom edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_now   = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_now & ~scl_hist;
  assign scl_fall  = ~scl_now & scl_hist;
  assign start_det = scl_now & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_slave_responder : I2C target with auto-increment register bus |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_pad_i (scl_pad_i),
    .sda_pad_i (sda_pad_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t     state, state_nxt, ack_next, ack_next_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_reg, shift_nxt, tx_reg, tx_nxt, ptr, ptr_nxt;
  logic [7:0] reg_addr_nxt, reg_wdata_nxt, rx_byte;
  logic       phase, phase_nxt, sda_oen, sda_oen_nxt, busy_nxt;
  logic       rd_wait, rd_wait_nxt, reg_wr_nxt, reg_rd_nxt;

  assign rx_byte      = {shift_reg[6:0], sda_s};
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ack_next  <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      tx_reg    <= 8'h00;
      ptr       <= 8'h00;
      phase     <= 1'b0;
      sda_oen   <= 1'b1;
      busy      <= 1'b0;
      rd_wait   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      ack_next  <= ack_next_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      tx_reg    <= tx_nxt;
      ptr       <= ptr_nxt;
      phase     <= phase_nxt;
      sda_oen   <= sda_oen_nxt;
      busy      <= busy_nxt;
      rd_wait   <= rd_wait_nxt;
      reg_wr    <= reg_wr_nxt;
      reg_rd    <= reg_rd_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ack_next_nxt  = ack_next;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_reg;
    tx_nxt        = tx_reg;
    ptr_nxt       = ptr;
    phase_nxt     = phase;
    sda_oen_nxt   = sda_oen;
    busy_nxt      = busy;
    rd_wait_nxt   = reg_rd;   // parent returns read data one clk after reg_rd
    reg_wr_nxt    = 1'b0;
    reg_rd_nxt    = 1'b0;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;

    if (stop_det) begin
      state_nxt   = ST_IDLE;
      sda_oen_nxt = I2C_NACK;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 4'd0;
      phase_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_DEV_ADDR;
      sda_oen_nxt = I2C_NACK;
      bit_cnt_nxt = 4'd0;
      phase_nxt   = 1'b0;
    end else begin
      case (state)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt  = 4'd0;
              phase_nxt    = 1'b0;
              state_nxt    = ST_ACK;
              ack_next_nxt = ST_WR_DATA;
              if (state == ST_DEV_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_nxt     = 1'b1;
                  ack_next_nxt = (rx_byte[0] == I2C_RW_READ) ? ST_RD_DATA : ST_REG_ADDR;
                end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = ST_IDLE;
                end
              end else if (state == ST_REG_ADDR) begin
                ptr_nxt = rx_byte;
              end else begin
                reg_wr_nxt    = 1'b1;
                reg_addr_nxt  = ptr;
                reg_wdata_nxt = rx_byte;
                ptr_nxt       = ptr + 8'd1;
              end
            end
          end
        end
        // phase 0: waiting for the fall after bit 8; phase 1: ACK being driven
        ST_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oen_nxt = I2C_ACK;
              phase_nxt   = 1'b1;
            end else begin
              sda_oen_nxt = I2C_NACK;
              phase_nxt   = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = ack_next;
              if (ack_next == ST_RD_DATA) begin
                reg_rd_nxt   = 1'b1;
                reg_addr_nxt = ptr;
              end
            end
          end
        end
        // bit_cnt counts bits already placed on SDA; zero until data is captured
        ST_RD_DATA: begin
          if (rd_wait) begin
            tx_nxt      = reg_rdata;
            sda_oen_nxt = reg_rdata[7];
            ptr_nxt     = ptr + 8'd1;
            bit_cnt_nxt = 4'd1;
          end else if (scl_fall && (bit_cnt != 4'd0)) begin
            if (bit_cnt == 4'd8) begin
              sda_oen_nxt = I2C_NACK;
              bit_cnt_nxt = 4'd0;
              phase_nxt   = 1'b0;
              state_nxt   = ST_RD_ACK;
            end else begin
              tx_nxt      = {tx_reg[6:0], 1'b0};
              sda_oen_nxt = tx_reg[6];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && !phase) begin
            if (sda_s == I2C_ACK) phase_nxt = 1'b1;
            else                  state_nxt = ST_IDLE;
          end else if (scl_fall && phase) begin
            phase_nxt    = 1'b0;
            bit_cnt_nxt  = 4'd0;
            state_nxt    = ST_RD_DATA;
            reg_rd_nxt   = 1'b1;
            reg_addr_nxt = ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
